mem_arbiter: RTL

- Shares the single-ported unified memory between instruction fetch (read-only) and the EX/MEM load-store path.
- Arbitrates per transaction and keeps at most one transaction outstanding.
- Generates byte enables and store-data lane replication from size and address.
- Aligns and sign/zero-extends load data. Flags misaligned data accesses without touching memory.

---
 rtl/mem_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Purpose: shares one single-ported memory between instruction fetch and the
//          load/store path; at most one transaction is outstanding at a time.
// Latency: request is driven combinationally in IDLE; the response is forwarded
//          to its owner in the same cycle as mem_rvalid.
// Backpressure: a grant is issued only when mem_ready=1; with mem_ready=0 the
//          request is re-driven each cycle.
// Ports: clk/reset (sync, active-high); if_* fetch port (req/gnt, rvalid/rdata);
//        d_* load/store port (req/gnt/err, rvalid/rdata); mem_* memory port.
module mem_arbiter #(
   parameter int unsigned FETCH_STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [2:0]  d_size,
   input  logic        d_sign,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_err,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

   localparam logic [3:0] STARVE_MAX = 4'(FETCH_STARVE_MAX);

   state_t      state, state_nxt;
   logic [3:0]  starve_cnt, starve_nxt;
   logic [1:0]  off_q;
   logic [2:0]  size_q;
   logic        sign_q;
   logic        we_q;

   logic [1:0]  d_off;
   logic        d_misaligned;
   logic        fetch_wins;
   logic        data_wins;
   logic [31:0] load_shift;
   logic [31:0] load_ext;

   // Fetch addresses are word aligned by contract; the low bits are dropped.
   logic unused_if_addr_lsb;
   assign unused_if_addr_lsb = ^if_addr[1:0];

   assign d_off = d_addr[1:0];

   always_comb begin
      d_misaligned = 1'b0;
      case (d_size)
         3'd1:    d_misaligned = 1'b0;
         3'd2:    d_misaligned = d_off[0];
         3'd4:    d_misaligned = (d_off != 2'b00);
         default: d_misaligned = 1'b1;
      endcase
   end

   // Data has priority unless fetch has been passed over FETCH_STARVE_MAX times.
   assign fetch_wins = if_req && (!d_req || (starve_cnt == STARVE_MAX));
   assign data_wins  = d_req && !fetch_wins;

   // Load alignment uses the offset/size/sign captured at grant time.
   assign load_shift = mem_rdata >> {off_q, 3'b000};

   always_comb begin
      load_ext = load_shift;
      case (size_q)
         3'd1:    load_ext = {{24{sign_q & load_shift[7]}},  load_shift[7:0]};
         3'd2:    load_ext = {{16{sign_q & load_shift[15]}}, load_shift[15:0]};
         default: load_ext = load_shift;
      endcase
   end

   always_comb begin
      state_nxt = state;
      if_gnt    = 1'b0;
      if_rvalid = 1'b0;
      if_rdata  = 32'd0;
      d_gnt     = 1'b0;
      d_err     = 1'b0;
      d_rvalid  = 1'b0;
      d_rdata   = 32'd0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'd0;
      mem_be    = 4'd0;
      mem_wdata = 32'd0;
      if (!reset) begin
         case (state)
            IDLE: begin
               if (fetch_wins) begin
                  mem_req  = 1'b1;
                  mem_addr = {if_addr[31:2], 2'b00};
                  mem_be   = 4'b1111;
                  if (mem_ready) begin
                     if_gnt    = 1'b1;
                     state_nxt = WAIT_I;
                  end
               end else if (data_wins) begin
                  if (d_misaligned) begin
                     // Rejected without touching memory, so no mem_ready needed.
                     d_gnt = 1'b1;
                     d_err = 1'b1;
                  end else begin
                     mem_req  = 1'b1;
                     mem_we   = d_we;
                     mem_addr = {d_addr[31:2], 2'b00};
                     if (d_we) begin
                        case (d_size)
                           3'd1: begin
                              mem_be    = 4'b0001 << d_off;
                              mem_wdata = {4{d_wdata[7:0]}};
                           end
                           3'd2: begin
                              mem_be    = 4'b0011 << d_off;
                              mem_wdata = {2{d_wdata[15:0]}};
                           end
                           default: begin
                              mem_be    = 4'b1111;
                              mem_wdata = d_wdata;
                           end
                        endcase
                     end else begin
                        mem_be = 4'b1111;
                     end
                     if (mem_ready) begin
                        d_gnt     = 1'b1;
                        state_nxt = WAIT_D;
                     end
                  end
               end
            end
            WAIT_I: begin
               if (mem_rvalid) begin
                  if_rvalid = 1'b1;
                  if_rdata  = mem_rdata;
                  state_nxt = IDLE;
               end
            end
            WAIT_D: begin
               if (mem_rvalid) begin
                  d_rvalid  = 1'b1;
                  d_rdata   = we_q ? 32'd0 : load_ext;
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Error rejections count as data grants for starvation purposes.
   always_comb begin
      starve_nxt = starve_cnt;
      if (!if_req || if_gnt)
         starve_nxt = 4'd0;
      else if (d_gnt && (starve_cnt != STARVE_MAX))
         starve_nxt = starve_cnt + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         starve_cnt <= 4'd0;
         off_q      <= 2'd0;
         size_q     <= 3'd0;
         sign_q     <= 1'b0;
         we_q       <= 1'b0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
         if (d_gnt && !d_err) begin
            off_q  <= d_off;
            size_q <= d_size;
            sign_q <= d_sign;
            we_q   <= d_we;
         end
      end
   end

endmodule
